// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared constants and types for the per-bin LED count interface
package led_pkg;

    localparam int LEDS_DEFAULT    = 50;
    localparam int BIN_QTY_DEFAULT = 12;

    localparam int LED_CW = $clog2(LEDS_DEFAULT);
    localparam int LED_BW = $clog2(BIN_QTY_DEFAULT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2
    } exp_state_t;

    // One frame's worth of per-bin LED counts as produced by the count calculator.
    typedef logic [BIN_QTY_DEFAULT-1:0][LED_CW-1:0] led_count_vec_t;

endpackage

// File: rtl/led_bin_expander.sv
// rtl/led_bin_expander.sv - expands per-bin LED counts into an ordered per-LED stream
module led_bin_expander
    import led_pkg::*;
#(
    parameter  int LEDS    = LEDS_DEFAULT,
    parameter  int BIN_QTY = BIN_QTY_DEFAULT,
    localparam int CW      = $clog2(LEDS),
    localparam int BW      = $clog2(BIN_QTY)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [BIN_QTY-1:0][CW-1:0]   LEDCount_i,
    input  logic                         data_v_i,
    output logic                         busy_o,
    output logic                         overrun_o,
    output logic                         led_v_o,
    input  logic                         led_ready_i,
    output logic [CW-1:0]                led_idx_o,
    output logic [BW-1:0]                led_bin_o,
    output logic                         frame_done_o
);

    // The last bin is the catch-all; its captured count is never consulted.
    localparam logic [BW-1:0] LAST_BIN = BW'(BIN_QTY - 1);
    localparam logic [BW-1:0] PEN_BIN  = BW'(BIN_QTY - 2);
    localparam logic [CW-1:0] IDX_LAST = CW'(LEDS - 1);
    localparam logic [CW-1:0] REM_ONE  = CW'(1);

    exp_state_t                 state;
    logic [BIN_QTY-1:0][CW-1:0] cnt_q;
    logic [BW-1:0]              bin;
    logic [CW-1:0]              idx;
    logic [CW-1:0]              rem;
    logic [BW-1:0]              bin_inc;
    logic [CW-1:0]              next_cnt;

    assign led_idx_o = idx;
    assign led_bin_o = bin;
    assign bin_inc   = bin + 1'b1;

    // Count for the bin after the current one; the catch-all bin loads zero since it is unlimited.
    always_comb begin
        next_cnt = '0;
        if (bin < PEN_BIN) begin
            next_cnt = cnt_q[bin_inc];
        end
    end

    // Capture, bin scan and per-LED emit sequencing with registered handshake/status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cnt_q        <= '0;
            bin          <= '0;
            idx          <= '0;
            rem          <= '0;
            busy_o       <= 1'b0;
            overrun_o    <= 1'b0;
            led_v_o      <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            overrun_o    <= 1'b0;
            frame_done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (data_v_i) begin
                        cnt_q  <= LEDCount_i;
                        bin    <= '0;
                        idx    <= '0;
                        rem    <= LEDCount_i[0];
                        busy_o <= 1'b1;
                        state  <= SCAN;
                    end
                end
                SCAN: begin
                    if (data_v_i) begin
                        overrun_o <= 1'b1;
                    end
                    if ((bin == LAST_BIN) || (rem != '0)) begin
                        led_v_o <= 1'b1;
                        state   <= EMIT;
                    end else begin
                        bin <= bin_inc;
                        rem <= next_cnt;
                    end
                end
                EMIT: begin
                    if (data_v_i) begin
                        overrun_o <= 1'b1;
                    end
                    if (led_ready_i) begin
                        if (idx == IDX_LAST) begin
                            // Frame complete: park the counters so the idle outputs read zero.
                            led_v_o      <= 1'b0;
                            busy_o       <= 1'b0;
                            frame_done_o <= 1'b1;
                            idx          <= '0;
                            bin          <= '0;
                            rem          <= '0;
                            state        <= IDLE;
                        end else begin
                            idx <= idx + 1'b1;
                            if (bin == LAST_BIN) begin
                                // Catch-all bin keeps emitting until the LED budget runs out.
                                rem <= rem;
                            end else if (rem == REM_ONE) begin
                                led_v_o <= 1'b0;
                                bin     <= bin_inc;
                                rem     <= next_cnt;
                                state   <= SCAN;
                            end else begin
                                rem <= rem - 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    led_v_o <= 1'b0;
                    busy_o  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_bin_expander.sv
// tb/tb_led_bin_expander.sv - directed self-checking bench for led_bin_expander
module tb_led_bin_expander;

    localparam int LEDS    = 50;
    localparam int BIN_QTY = 12;
    localparam int CW      = 6;
    localparam int BW      = 4;

    typedef logic [BIN_QTY-1:0][CW-1:0] cvec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    cvec_t         LEDCount_i = '0;
    logic          data_v_i = 1'b0;
    logic          busy_o;
    logic          overrun_o;
    logic          led_v_o;
    logic          led_ready_i = 1'b0;
    logic [CW-1:0] led_idx_o;
    logic [BW-1:0] led_bin_o;
    logic          frame_done_o;

    int checks   = 0;
    int failures = 0;

    led_bin_expander dut (
        .clk          (clk),
        .rst          (rst),
        .LEDCount_i   (LEDCount_i),
        .data_v_i     (data_v_i),
        .busy_o       (busy_o),
        .overrun_o    (overrun_o),
        .led_v_o      (led_v_o),
        .led_ready_i  (led_ready_i),
        .led_idx_o    (led_idx_o),
        .led_bin_o    (led_bin_o),
        .frame_done_o (frame_done_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Owning bin of LED n: cumulative walk over bins 0..BIN_QTY-2, remainder to the last bin.
    function automatic int exp_bin(input cvec_t c, input int n);
        int cum;
        cum = 0;
        for (int b = 0; b < BIN_QTY - 1; b++) begin
            cum += int'(c[b]);
            if (n < cum) return b;
        end
        return BIN_QTY - 1;
    endfunction

    // Runs one frame from capture to frame_done, returning at the frame_done observation point.
    task automatic run_frame(input cvec_t c, input bit alt_ready, input int ovr_at, input int rst_at);
        int  n;
        int  cyc;
        int  k;
        int  ovr_phase;
        int  done_cnt;
        bit  first_seen;
        bit  hs;
        bit  done;
        n = 0; cyc = 0; ovr_phase = 0; done_cnt = 0; first_seen = 0; done = 0;
        k = BIN_QTY;
        for (int b = BIN_QTY - 2; b >= 0; b--) if (c[b] != '0) k = b + 1;

        LEDCount_i  = c;
        data_v_i    = 1'b1;
        led_ready_i = alt_ready ? 1'b0 : 1'b1;
        step();
        data_v_i = 1'b0;
        check("cap_busy", busy_o, 1);
        check("cap_valid", led_v_o, 0);
        check("cap_done", frame_done_o, 0);
        check("cap_overrun", overrun_o, 0);

        while (!done && cyc < 400) begin
            if (ovr_phase == 1) begin
                check("overrun_pulse", overrun_o, 1);
                data_v_i  = 1'b0;
                ovr_phase = 2;
            end else begin
                check("overrun_quiet", overrun_o, 0);
            end
            check("busy_mid", busy_o, 1);
            check("done_mid", frame_done_o, 0);
            hs = 1'b0;
            if (led_v_o) begin
                if (!first_seen) begin
                    first_seen = 1;
                    check("first_valid_latency", cyc, k);
                end
                check("led_idx", led_idx_o, n);
                check("led_bin", led_bin_o, exp_bin(c, n));
                if (rst_at == n) begin
                    #2 rst = 1'b0;
                    #1;
                    check("rst_valid", led_v_o, 0);
                    check("rst_busy", busy_o, 0);
                    check("rst_idx", led_idx_o, 0);
                    check("rst_bin", led_bin_o, 0);
                    check("rst_done", frame_done_o, 0);
                    check("rst_overrun", overrun_o, 0);
                    return;
                end
                if (ovr_at == n && ovr_phase == 0) begin
                    LEDCount_i = ~c;
                    data_v_i   = 1'b1;
                    ovr_phase  = 1;
                end
                hs = led_ready_i;
            end
            step();
            cyc++;
            if (alt_ready) led_ready_i = ~led_ready_i;
            if (hs) n++;
            if (frame_done_o) done_cnt++;
            if (n == LEDS) done = 1;
        end
        check("frame_len", n, LEDS);
        check("end_done", frame_done_o, 1);
        check("end_done_count", done_cnt, 1);
        check("end_busy", busy_o, 0);
        check("end_valid", led_v_o, 0);
    endtask

    initial begin
        cvec_t c1, c2, cz, c3;
        c1 = '0; c1[0] = 6'd5; c1[2] = 6'd3;
        c2 = '0; c2[0] = 6'd40; c2[1] = 6'd20;
        cz = '0;
        c3 = '0; c3[3] = 6'd60; c3[11] = 6'd7;

        rst = 1'b0;
        step();
        step();
        check("reset_valid", led_v_o, 0);
        check("reset_busy", busy_o, 0);
        check("reset_done", frame_done_o, 0);
        check("reset_overrun", overrun_o, 0);
        check("reset_idx", led_idx_o, 0);
        check("reset_bin", led_bin_o, 0);
        rst = 1'b1;
        step();

        // Second frame captured in the very cycle frame_done is high.
        run_frame(c1, 1'b0, -1, -1);
        run_frame(c2, 1'b0, -1, -1);
        step();
        check("idle_after_done", frame_done_o, 0);

        run_frame(cz, 1'b0, -1, -1);
        step();
        run_frame(c1, 1'b1, -1, -1);
        step();
        led_ready_i = 1'b1;
        run_frame(c1, 1'b0, 20, -1);
        step();
        run_frame(c1, 1'b0, -1, 30);
        step();
        step();
        check("held_reset_valid", led_v_o, 0);
        rst = 1'b1;
        step();
        run_frame(c1, 1'b0, -1, -1);
        step();
        run_frame(c3, 1'b0, -1, -1);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
